// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined two's-complement adder/subtractor, one CHUNK-bit slice per stage
// Carry ripples one slice per cycle; stages collapse bubbles under valid/ready flow control.
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero
);
  localparam int STAGES = WIDTH / CHUNK;

  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              c_q [STAGES];
  logic              v_q [STAGES];
  logic [STAGES-1:0] full;
  logic [STAGES-1:0] rdy;
  logic              ovf_q;
  logic              zero_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] s_next;
    logic             c_in;
    logic             v_in;
    logic [CHUNK:0]   slice;

    assign full[k] = v_q[k];
    // Closed form of the ready chain: a stage may load if it or any later stage has room.
    assign rdy[k]  = i_ready | ~&full[STAGES-1:k];

    if (k == 0) begin : g_first
      assign a_in = i_a;
      assign b_in = i_sub ? ~i_b : i_b;
      assign c_in = i_sub ? ~i_cin : i_cin;
      assign s_in = '0;
      assign v_in = i_valid & rdy[0];
    end else begin : g_next
      assign a_in = a_q[k-1];
      assign b_in = b_q[k-1];
      assign c_in = c_q[k-1];
      assign s_in = s_q[k-1];
      assign v_in = v_q[k-1];
    end

    assign slice = {1'b0, a_in[k*CHUNK +: CHUNK]} + {1'b0, b_in[k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, c_in};

    always_comb begin
      s_next = s_in;
      s_next[k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end else if (rdy[k]) begin
        a_q[k] <= a_in;
        b_q[k] <= b_in;
        s_q[k] <= s_next;
        c_q[k] <= slice[CHUNK];
        v_q[k] <= v_in;
      end
    end

    if (k == STAGES - 1) begin : g_flags
      logic c_msb_in;
      // Carry into the MSB recovered from the MSB sum bit and its operand bits.
      assign c_msb_in = slice[CHUNK-1] ^ a_in[WIDTH-1] ^ b_in[WIDTH-1];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (rdy[k]) begin
          ovf_q  <= c_msb_in ^ slice[CHUNK];
          zero_q <= (s_next == '0);
        end
      end
    end
  end

  assign o_ready = rdy[0];
  assign o_valid = v_q[STAGES-1];
  assign o_sum   = s_q[STAGES-1];
  assign o_cout  = c_q[STAGES-1];
  assign o_ovf   = ovf_q;
  assign o_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - scoreboard bench for pipelined_addsub (WIDTH=16, CHUNK=4)
module tb_pipelined_addsub;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [15:0] i_a = '0;
  logic [15:0] i_b = '0;
  logic        i_cin = 1'b0;
  logic        i_sub = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [15:0] o_sum;
  logic        o_cout;
  logic        o_ovf;
  logic        o_zero;

  pipelined_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_cin(i_cin), .i_sub(i_sub),
    .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum),
    .o_cout(o_cout), .o_ovf(o_ovf), .o_zero(o_zero)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    logic        z;
    int          acc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   inflight = 0;
  bit   in_rst = 1'b1;
  bit   rnd_ready = 1'b0;
  bit   stall_en = 1'b0;
  int   stall_base = 0;
  bit   stall_prev = 1'b0;
  logic [18:0] held;

  // Hand-computed vectors: a, b, cin, sub -> sum, cout, ovf
  vec_t stream_vecs[10] = '{
    '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0},
    '{16'hF000, 16'h1000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0},
    '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0},
    '{16'h1000, 16'h2000, 1'b0, 1'b1, 16'hF000, 1'b0, 1'b0},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
    '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1},
    '{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0},
    '{16'h1234, 16'h1233, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0}
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge i_clk) cyc++;

  always @(posedge i_clk) begin
    #1;
    if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
    else i_ready = !(stall_en && (cyc - stall_base) >= 6 && (cyc - stall_base) <= 8);
  end

  // Monitor: pops the scoreboard on each completed output, checks stall stability and o_ready.
  always @(negedge i_clk) begin
    exp_t e;
    if (!in_rst) begin
      if (stall_prev) begin
        chk("stall_valid", o_valid, 1);
        chk("stall_hold", {o_sum, o_cout, o_ovf, o_zero}, held);
      end
      chk("o_ready", o_ready, i_ready || (inflight < 4));
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_output", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sum", o_sum, e.s);
          chk("cout", o_cout, e.c);
          chk("ovf", o_ovf, e.o);
          chk("zero", o_zero, e.z);
          if (e.lat) chk("latency", cyc - e.acc, 3);
        end
      end
      stall_prev = o_valid && !i_ready;
      held = {o_sum, o_cout, o_ovf, o_zero};
      inflight += ((i_valid && o_ready) ? 1 : 0) - ((o_valid && i_ready) ? 1 : 0);
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sub, input logic [15:0] es, input logic ec,
                      input logic eo, input bit lat);
    exp_t e;
    int n;
    @(posedge i_clk);
    #1;
    i_valid = 1'b1;
    i_a = a;
    i_b = b;
    i_cin = cin;
    i_sub = sub;
    @(negedge i_clk);
    n = 0;
    while (!o_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      e.s = es; e.c = ec; e.o = eo; e.z = (es == 16'h0000);
      e.acc = cyc + 1; e.lat = lat;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    #13;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_flags", {o_sum, o_cout, o_ovf, o_zero}, 0);
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b1;
    in_rst = 1'b0;

    // Directed single ops with latency checks
    send(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b1); idle(); drain();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1); idle(); drain();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1); idle(); drain();
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1); idle(); drain();
    send(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1); idle(); drain();
    send(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1); idle(); drain();

    // Back-to-back stream with a three-cycle downstream stall
    stall_base = cyc;
    stall_en = 1'b1;
    foreach (stream_vecs[i])
      send(stream_vecs[i].a, stream_vecs[i].b, stream_vecs[i].cin, stream_vecs[i].sub,
           stream_vecs[i].s, stream_vecs[i].c, stream_vecs[i].o, 1'b0);
    idle();
    drain();
    stall_en = 1'b0;

    // Bubbles with random downstream readiness
    rnd_ready = 1'b1;
    foreach (stream_vecs[i]) begin
      send(stream_vecs[i].a, stream_vecs[i].b, stream_vecs[i].cin, stream_vecs[i].sub,
           stream_vecs[i].s, stream_vecs[i].c, stream_vecs[i].o, 1'b0);
      idle();
    end
    rnd_ready = 1'b0;
    drain();
    repeat (2) @(posedge i_clk);

    // Asynchronous reset with three ops in flight, first one already presented
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
    send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    idle();
    @(posedge i_clk);
    #3;
    in_rst = 1'b1;
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_valid", o_valid, 0);
    chk("async_rst_outs", {o_sum, o_cout, o_ovf, o_zero}, 0);
    chk("async_rst_ready", o_ready, 1);
    sb.delete();
    inflight = 0;
    stall_prev = 1'b0;
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b1;
    in_rst = 1'b0;
    repeat (6) begin
      @(negedge i_clk);
      #1;
      chk("post_rst_idle", o_valid, 0);
    end
    send(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b1);
    idle();
    drain();

    repeat (2) @(posedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
